// File: rtl/idle_off.sv
// idle_off: main-side end of the power handshake.
// Tracks user activity and datapath load while the power block holds rst_n high.
// The session ends on an explicit off request or after an idle timeout with a
// blinking warning window. The datapath is quiesced and must drain, then
// main_done pulses once so the power block can drop rst_n.
module idle_off #(
    parameter int CYCLES_PER_MS = 1000,
    parameter int IDLE_CMAX     = 30000 * CYCLES_PER_MS,
    parameter int WARN_CMAX     = 5000 * CYCLES_PER_MS,
    parameter int BLINK_CMAX    = 250 * CYCLES_PER_MS,
    parameter int DRAIN_CMAX    = 10 * CYCLES_PER_MS
) (
    input  logic clk,
    input  logic rst_n,
    input  logic act,
    input  logic busy,
    input  logic req_off,
    output logic quiesce,
    output logic led_warn,
    output logic main_done
);

    // One counter width covers every timeout so no counter can wrap.
    localparam int MAX_AB = (IDLE_CMAX > WARN_CMAX) ? IDLE_CMAX : WARN_CMAX;
    localparam int MAX_CD = (BLINK_CMAX > DRAIN_CMAX) ? BLINK_CMAX : DRAIN_CMAX;
    localparam int MAX_C  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CW     = (MAX_C < 2) ? 1 : $clog2(MAX_C + 1);

    // Counters hold the number of edges already seen, so "last" is CMAX-1.
    localparam logic [CW-1:0] IDLE_LAST  = CW'(IDLE_CMAX - 1);
    localparam logic [CW-1:0] WARN_LAST  = CW'(WARN_CMAX - 1);
    localparam logic [CW-1:0] BLINK_LAST = CW'(BLINK_CMAX - 1);
    localparam logic [CW-1:0] DRAIN_LAST = CW'(DRAIN_CMAX - 1);

    typedef enum logic [2:0] {
        S_RUN   = 3'd0,
        S_WARN  = 3'd1,
        S_DRAIN = 3'd2,
        S_DONE  = 3'd3,
        S_HALT  = 3'd4
    } state_t;

    state_t state;
    state_t state_next;

    logic [CW-1:0] idle_cnt;
    logic [CW-1:0] warn_cnt;
    logic [CW-1:0] blink_cnt;
    logic [CW-1:0] drain_cnt;

    logic idle;
    logic idle_hit;
    logic warn_hit;
    logic blink_hit;
    logic drain_hit;

    logic quiesce_d;
    logic led_warn_d;
    logic main_done_d;

    assign idle      = !act && !busy;
    assign idle_hit  = (idle_cnt == IDLE_LAST);
    assign warn_hit  = (warn_cnt == WARN_LAST);
    assign blink_hit = (blink_cnt == BLINK_LAST);
    assign drain_hit = (drain_cnt == DRAIN_LAST);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_RUN;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decision; req_off outranks activity in RUN and WARN.
    always_comb begin
        state_next = state;
        case (state)
            S_RUN: begin
                if (req_off) begin
                    state_next = S_DRAIN;
                end else if (idle && idle_hit) begin
                    state_next = S_WARN;
                end
            end
            S_WARN: begin
                if (req_off) begin
                    state_next = S_DRAIN;
                end else if (act || busy) begin
                    state_next = S_RUN;
                end else if (warn_hit) begin
                    state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!busy && drain_hit) begin
                    state_next = S_DONE;
                end
            end
            S_DONE:  state_next = S_HALT;
            S_HALT:  state_next = S_HALT;
            default: state_next = S_RUN;
        endcase
    end

    // Counters advance only while the state persists and clear on any exit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt  <= '0;
            warn_cnt  <= '0;
            blink_cnt <= '0;
            drain_cnt <= '0;
        end else begin
            idle_cnt  <= (state == S_RUN && state_next == S_RUN && idle) ?
                         idle_cnt + 1'b1 : '0;
            warn_cnt  <= (state == S_WARN && state_next == S_WARN) ?
                         warn_cnt + 1'b1 : '0;
            blink_cnt <= (state == S_WARN && state_next == S_WARN && !blink_hit) ?
                         blink_cnt + 1'b1 : '0;
            drain_cnt <= (state == S_DRAIN && state_next == S_DRAIN && !busy) ?
                         drain_cnt + 1'b1 : '0;
        end
    end

    // Output values for the upcoming state; the LED starts lit on WARN entry.
    always_comb begin
        quiesce_d   = (state_next == S_DRAIN) || (state_next == S_DONE) ||
                      (state_next == S_HALT);
        main_done_d = (state_next == S_DONE);
        led_warn_d  = 1'b0;
        if (state_next == S_WARN) begin
            if (state != S_WARN) begin
                led_warn_d = 1'b1;
            end else if (blink_hit) begin
                led_warn_d = !led_warn;
            end else begin
                led_warn_d = led_warn;
            end
        end
    end

    // Registered outputs, cleared asynchronously by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quiesce   <= 1'b0;
            led_warn  <= 1'b0;
            main_done <= 1'b0;
        end else begin
            quiesce   <= quiesce_d;
            led_warn  <= led_warn_d;
            main_done <= main_done_d;
        end
    end

endmodule

// File: tb/tb_idle_off.sv
// tb_idle_off: table vectors, directed corner sequences and random sessions,
// all compared against a behavioural model of the power-off rules.
module tb_idle_off;

    localparam int I_CMAX = 8;
    localparam int W_CMAX = 6;
    localparam int B_CMAX = 2;
    localparam int D_CMAX = 3;

    localparam int P_RUN   = 0;
    localparam int P_WARN  = 1;
    localparam int P_DRAIN = 2;
    localparam int P_DONE  = 3;
    localparam int P_HALT  = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic act = 1'b0;
    logic busy = 1'b0;
    logic req_off = 1'b0;
    logic quiesce;
    logic led_warn;
    logic main_done;

    int checks = 0;
    int errors = 0;

    // Model: phase plus "how long" figures; LED derived from time in WARN.
    int m_phase;
    int m_idle;
    int m_age;
    int m_drain;

    typedef struct {
        logic a;
        logic b;
        logic r;
        logic q;
        logic l;
        logic d;
    } vec_t;

    vec_t tbl[19];

    idle_off #(
        .IDLE_CMAX (I_CMAX),
        .WARN_CMAX (W_CMAX),
        .BLINK_CMAX(B_CMAX),
        .DRAIN_CMAX(D_CMAX)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .act      (act),
        .busy     (busy),
        .req_off  (req_off),
        .quiesce  (quiesce),
        .led_warn (led_warn),
        .main_done(main_done)
    );

    always #5 clk = ~clk;

    task automatic compare(input string name, input logic actual, input logic expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %b expected %b", name, $time, actual, expected);
        end
    endtask

    task automatic compare_int(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %0d expected %0d", name, $time, actual, expected);
        end
    endtask

    task automatic model_reset();
        m_phase = P_RUN;
        m_idle  = 0;
        m_age   = 0;
        m_drain = 0;
    endtask

    task automatic model_step(input logic a, input logic b, input logic r);
        case (m_phase)
            P_RUN: begin
                if (r) begin
                    m_phase = P_DRAIN;
                    m_drain = 0;
                end else if (!a && !b) begin
                    m_idle++;
                    if (m_idle == I_CMAX) begin
                        m_phase = P_WARN;
                        m_age   = 0;
                        m_idle  = 0;
                    end
                end else begin
                    m_idle = 0;
                end
            end
            P_WARN: begin
                if (r) begin
                    m_phase = P_DRAIN;
                    m_drain = 0;
                end else if (a || b) begin
                    m_phase = P_RUN;
                    m_idle  = 0;
                end else begin
                    m_age++;
                    if (m_age == W_CMAX) begin
                        m_phase = P_DRAIN;
                        m_drain = 0;
                    end
                end
            end
            P_DRAIN: begin
                m_drain = b ? 0 : m_drain + 1;
                if (m_drain == D_CMAX) m_phase = P_DONE;
            end
            default: m_phase = P_HALT;
        endcase
    endtask

    task automatic check_output(input string tag);
        compare({tag, ".quiesce"}, quiesce, m_phase >= P_DRAIN);
        compare({tag, ".led_warn"}, led_warn, (m_phase == P_WARN) && (((m_age / B_CMAX) % 2) == 0));
        compare({tag, ".main_done"}, main_done, m_phase == P_DONE);
    endtask

    // Drive inputs, take one clock edge, advance the model, sample 1ns later.
    task automatic apply_stimulus(input logic a, input logic b, input logic r);
        act     = a;
        busy    = b;
        req_off = r;
        @(posedge clk);
        model_step(a, b, r);
        #1;
    endtask

    task automatic step(input string tag, input logic a, input logic b, input logic r);
        apply_stimulus(a, b, r);
        check_output(tag);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n   = 1'b0;
        act     = 1'b0;
        busy    = 1'b0;
        req_off = 1'b0;
        #1;
        compare("reset.quiesce", quiesce, 1'b0);
        compare("reset.led_warn", led_warn, 1'b0);
        compare("reset.main_done", main_done, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic run_table(input string tag);
        for (int i = 0; i < 19; i++) begin
            apply_stimulus(tbl[i].a, tbl[i].b, tbl[i].r);
            compare($sformatf("%s[%0d].quiesce", tag, i), quiesce, tbl[i].q);
            compare($sformatf("%s[%0d].led_warn", tag, i), led_warn, tbl[i].l);
            compare($sformatf("%s[%0d].main_done", tag, i), main_done, tbl[i].d);
        end
    endtask

    initial begin
        int n;
        int dones;
        int seen;
        logic blvl;

        // Idle from reset release: 7 RUN samples, 6 WARN, 3 DRAIN, DONE, HALT.
        for (int i = 0; i < 19; i++) begin
            tbl[i] = '{a: 1'b0, b: 1'b0, r: 1'b0, q: 1'b0, l: 1'b0, d: 1'b0};
            if (i >= 13) tbl[i].q = 1'b1;
            if (i == 16) tbl[i].d = 1'b1;
        end
        tbl[7].l  = 1'b1;
        tbl[8].l  = 1'b1;
        tbl[11].l = 1'b1;
        tbl[12].l = 1'b1;

        model_reset();
        do_reset();
        run_table("idle_table");

        // act in the third WARN cycle returns to RUN and restarts the idle wait.
        do_reset();
        for (int i = 0; i < 10; i++) step("s2.pre", 1'b0, 1'b0, 1'b0);
        step("s2.act", 1'b1, 1'b0, 1'b0);
        compare("s2.led_after_act", led_warn, 1'b0);
        n = 0;
        while (led_warn !== 1'b1 && n < 20) begin
            step("s2.idle", 1'b0, 1'b0, 1'b0);
            n++;
        end
        compare_int("s2.rewarn_cycles", n, I_CMAX);

        // req_off while busy: quiesce at once, main_done 3 cycles after busy drops.
        do_reset();
        for (int i = 0; i < 3; i++) step("s3.pre", 1'b0, 1'b0, 1'b0);
        step("s3.req", 1'b0, 1'b1, 1'b1);
        compare("s3.quiesce_next", quiesce, 1'b1);
        for (int i = 0; i < 5; i++) step("s3.busy", 1'b0, 1'b1, 1'b0);
        compare("s3.no_done_busy", main_done, 1'b0);
        n = 0;
        while (main_done !== 1'b1 && n < 20) begin
            step("s3.drain", 1'b0, 1'b0, 1'b0);
            n++;
        end
        compare_int("s3.drain_cycles", n, D_CMAX);

        // Long busy never warns; WARN follows 8 idle cycles after busy ends.
        do_reset();
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            step("s4.busy", 1'b0, 1'b1, 1'b0);
            if (led_warn === 1'b1) seen++;
        end
        compare_int("s4.warn_during_busy", seen, 0);
        n = 0;
        while (led_warn !== 1'b1 && n < 20) begin
            step("s4.idle", 1'b0, 1'b0, 1'b0);
            n++;
        end
        compare_int("s4.warn_cycles", n, I_CMAX);

        // Asynchronous reset mid-DRAIN clears outputs without a clock edge.
        do_reset();
        step("s5.req", 1'b0, 1'b1, 1'b1);
        step("s5.hold", 1'b0, 1'b1, 1'b0);
        compare("s5.quiesce_before", quiesce, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        compare("s5.async.quiesce", quiesce, 1'b0);
        compare("s5.async.led_warn", led_warn, 1'b0);
        compare("s5.async.main_done", main_done, 1'b0);
        busy = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        run_table("after_async");

        // req_off beats act; later pulses after HALT give no second main_done.
        do_reset();
        step("s6.pre", 1'b0, 1'b0, 1'b0);
        step("s6.both", 1'b1, 1'b0, 1'b1);
        compare("s6.quiesce", quiesce, 1'b1);
        dones = 0;
        for (int i = 0; i < 16; i++) begin
            step("s6.post", i[0], 1'b0, !i[0]);
            if (main_done === 1'b1) dones++;
        end
        compare_int("s6.done_pulses", dones, 1);
        compare("s6.halt_quiesce", quiesce, 1'b1);

        // Random sessions with bursty busy and rare requests.
        for (int s = 0; s < 24; s++) begin
            do_reset();
            blvl = 1'b0;
            for (int c = 0; c < 300; c++) begin
                if ($urandom % 10 == 0) blvl = !blvl;
                step("rand", ($urandom % 14) == 0, blvl, ($urandom % 120) == 0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
